// File: rtl/cpu_arith_unit.sv
// RV32 execute-stage integer datapath: combinational ALU, 2-cycle pipelined 32x32->64
// multiplier and a 33-cycle restoring radix-2 divider sharing one latch strobe.
module cpu_arith_unit (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [3:0]  i_alu_op,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  input  logic        i_latch,
  input  logic        i_signed,
  output logic [31:0] o_result,
  output logic [31:0] o_shift_result,
  output logic [31:0] o_signed_sum_result,
  output logic        o_compare_result,
  output logic [63:0] o_mul_result,
  output logic        o_mul_done,
  output logic [31:0] o_div_result,
  output logic [31:0] o_div_remainder,
  output logic        o_div_done
);

  // ---------------------------------------------------------------- ALU
  logic [4:0] shamt;
  assign shamt               = i_op2[4:0];
  assign o_signed_sum_result = i_op1 + i_op2;

  always_comb begin
    o_result         = '0;
    o_shift_result   = '0;
    o_compare_result = 1'b0;
    case (i_alu_op)
      4'd0:    o_result = i_op1 + i_op2;
      4'd1:    o_result = i_op1 - i_op2;
      4'd2:    o_result = i_op1 & i_op2;
      4'd3:    o_result = i_op1 | i_op2;
      4'd4:    o_result = i_op1 ^ i_op2;
      4'd5:    o_shift_result = i_op1 << shamt;
      4'd6:    o_shift_result = i_op1 >> shamt;
      4'd7:    o_shift_result = $signed(i_op1) >>> shamt;
      4'd8:    o_compare_result = $signed(i_op1) < $signed(i_op2);
      4'd9:    o_compare_result = i_op1 < i_op2;
      4'd10:   o_compare_result = i_op1 == i_op2;
      4'd11:   o_compare_result = i_op1 != i_op2;
      4'd12:   o_compare_result = $signed(i_op1) >= $signed(i_op2);
      4'd13:   o_compare_result = i_op1 >= i_op2;
      default: ;
    endcase
  end

  // ---------------------------------------------------------- Multiplier
  logic [31:0] mul_a_q, mul_b_q;
  logic        mul_sgn_q, mul_v0_q, mul_v1_q, mul_done_q;
  logic [63:0] prod_q, mul_res_q, prod;
  logic [32:0] mul_a_ext, mul_b_ext;

  // Sign- or zero-extend to 33 bits so one signed multiply covers both modes.
  assign mul_a_ext = {mul_sgn_q & mul_a_q[31], mul_a_q};
  assign mul_b_ext = {mul_sgn_q & mul_b_q[31], mul_b_q};
  assign prod      = 64'($signed(mul_a_ext) * $signed(mul_b_ext));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_sgn_q  <= 1'b0;
      mul_v0_q   <= 1'b0;
      mul_v1_q   <= 1'b0;
      prod_q     <= '0;
      mul_res_q  <= '0;
      mul_done_q <= 1'b0;
    end else if (i_latch) begin
      mul_a_q    <= i_op1;
      mul_b_q    <= i_op2;
      mul_sgn_q  <= i_signed;
      mul_v0_q   <= 1'b1;
      mul_v1_q   <= 1'b0;
      mul_done_q <= 1'b0;
    end else begin
      mul_v0_q <= 1'b0;
      mul_v1_q <= mul_v0_q;
      if (mul_v0_q) prod_q <= prod;
      if (mul_v1_q) begin
        mul_res_q  <= prod_q;
        mul_done_q <= 1'b1;
      end
    end
  end

  assign o_mul_result = mul_res_q;
  assign o_mul_done   = mul_done_q;

  // ------------------------------------------------------------- Divider
  typedef enum logic [1:0] {StIdle, StRun, StFix} div_state_e;
  div_state_e  st_q, st_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, den_q, den_d, num_q, num_d;
  logic [31:0] div_res_q, div_res_d, div_rem_q, div_rem_d;
  logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d, den_zero_q, den_zero_d;
  logic        div_done_q, div_done_d;
  logic [32:0] r_sh, diff;

  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    den_d      = den_q;
    num_d      = num_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    den_zero_d = den_zero_q;
    div_res_d  = div_res_q;
    div_rem_d  = div_rem_q;
    div_done_d = div_done_q;
    r_sh       = {rem_q, quo_q[31]};
    diff       = r_sh - {1'b0, den_q};
    if (i_latch) begin
      st_d       = StRun;
      cnt_d      = '0;
      rem_d      = '0;
      quo_d      = (i_signed && i_op1[31]) ? -i_op1 : i_op1;
      den_d      = (i_signed && i_op2[31]) ? -i_op2 : i_op2;
      num_d      = i_op1;
      q_neg_d    = i_signed & (i_op1[31] ^ i_op2[31]);
      r_neg_d    = i_signed & i_op1[31];
      den_zero_d = (i_op2 == '0);
      div_done_d = 1'b0;
    end else begin
      case (st_q)
        StRun: begin
          // Borrow out of bit 32 means the trial subtraction went negative: restore.
          if (!diff[32]) begin
            rem_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = r_sh[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) st_d = StFix;
        end
        StFix: begin
          st_d       = StIdle;
          div_done_d = 1'b1;
          if (den_zero_q) begin
            div_res_d = 32'hFFFF_FFFF;
            div_rem_d = num_q;
          end else begin
            div_res_d = q_neg_q ? -quo_q : quo_q;
            div_rem_d = r_neg_q ? -rem_q : rem_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      st_q       <= StIdle;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      den_q      <= '0;
      num_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      den_zero_q <= 1'b0;
      div_res_q  <= '0;
      div_rem_q  <= '0;
      div_done_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      den_q      <= den_d;
      num_q      <= num_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      den_zero_q <= den_zero_d;
      div_res_q  <= div_res_d;
      div_rem_q  <= div_rem_d;
      div_done_q <= div_done_d;
    end
  end

  assign o_div_result    = div_res_q;
  assign o_div_remainder = div_rem_q;
  assign o_div_done      = div_done_q;

endmodule

// File: tb/tb_cpu_arith_unit.sv
// Self-checking bench for cpu_arith_unit: directed corner cases plus randomized operands
// compared against a plain-arithmetic reference model.
module tb_cpu_arith_unit;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [3:0]  i_alu_op = '0;
  logic [31:0] i_op1 = '0, i_op2 = '0;
  logic        i_latch = 1'b0, i_signed = 1'b0;
  logic [31:0] o_result, o_shift_result, o_signed_sum_result;
  logic        o_compare_result;
  logic [63:0] o_mul_result;
  logic        o_mul_done;
  logic [31:0] o_div_result, o_div_remainder;
  logic        o_div_done;

  int checks = 0;
  int failures = 0;

  cpu_arith_unit dut (
    .i_clock             (i_clock),
    .i_reset             (i_reset),
    .i_alu_op            (i_alu_op),
    .i_op1               (i_op1),
    .i_op2               (i_op2),
    .i_latch             (i_latch),
    .i_signed            (i_signed),
    .o_result            (o_result),
    .o_shift_result      (o_shift_result),
    .o_signed_sum_result (o_signed_sum_result),
    .o_compare_result    (o_compare_result),
    .o_mul_result        (o_mul_result),
    .o_mul_done          (o_mul_done),
    .o_div_result        (o_div_result),
    .o_div_remainder     (o_div_remainder),
    .o_div_done          (o_div_done)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: whole-number arithmetic on 64-bit integers.
  function automatic void alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [31:0] sh, output logic c);
    longint sa, sb, ua, ub;
    int n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    n  = int'(b % 32);
    r  = '0;
    sh = '0;
    c  = 1'b0;
    case (op)
      4'd0:  r  = 32'(ua + ub);
      4'd1:  r  = 32'(ua - ub);
      4'd2:  r  = a & b;
      4'd3:  r  = a | b;
      4'd4:  r  = a ^ b;
      4'd5:  sh = 32'(ua * (longint'(1) << n));
      4'd6:  sh = 32'(ua / (longint'(1) << n));
      4'd7:  sh = 32'(sa >>> n);
      4'd8:  c  = sa < sb;
      4'd9:  c  = ua < ub;
      4'd10: c  = ua == ub;
      4'd11: c  = ua != ub;
      4'd12: c  = sa >= sb;
      4'd13: c  = ua >= ub;
      default: ;
    endcase
  endfunction

  function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    if (s) return 64'(longint'($signed(a)) * longint'($signed(b)));
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic void div_ref(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic do_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r, sh;
    logic c;
    @(negedge i_clock);
    i_alu_op = op;
    i_op1    = a;
    i_op2    = b;
    #1;
    alu_ref(op, a, b, r, sh, c);
    check($sformatf("alu_result op%0d", op), 64'(o_result), 64'(r));
    check($sformatf("alu_shift op%0d", op), 64'(o_shift_result), 64'(sh));
    check($sformatf("alu_cmp op%0d", op), 64'(o_compare_result), 64'(c));
    check("alu_sum", 64'(o_signed_sum_result), 64'(32'(a + b)));
  endtask

  // Drives a one-cycle latch; returns at the negedge after latch edge N.
  task automatic latch_ops(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge i_clock);
    i_op1    = a;
    i_op2    = b;
    i_signed = s;
    i_latch  = 1'b1;
    @(posedge i_clock);
    @(negedge i_clock);
    i_latch  = 1'b0;
    i_op1    = $urandom;
    i_op2    = $urandom;
    i_signed = ~s;
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    latch_ops(a, b, s);
    @(posedge i_clock);
    @(negedge i_clock);
    check("mul_done_early", 64'(o_mul_done), 64'd0);
    @(posedge i_clock);
    @(negedge i_clock);
    check("mul_done", 64'(o_mul_done), 64'd1);
    check("mul_result", o_mul_result, mul_ref(a, b, s));
  endtask

  // Assumes latch edge N already happened (called at negedge after N).
  task automatic finish_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q, r;
    repeat (32) @(posedge i_clock);
    @(negedge i_clock);
    check("div_done_early", 64'(o_div_done), 64'd0);
    @(posedge i_clock);
    @(negedge i_clock);
    div_ref(a, b, s, q, r);
    check("div_done", 64'(o_div_done), 64'd1);
    check("div_quotient", 64'(o_div_result), 64'(q));
    check("div_remainder", 64'(o_div_remainder), 64'(r));
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    latch_ops(a, b, s);
    finish_div(a, b, s);
  endtask

  initial begin
    logic [31:0] a, b;
    // Reset: registered outputs clear asynchronously.
    #2 i_reset = 1'b0;
    #1;
    check("rst_mul_done", 64'(o_mul_done), 64'd0);
    check("rst_mul_result", o_mul_result, 64'd0);
    check("rst_div_done", 64'(o_div_done), 64'd0);
    check("rst_div_result", 64'(o_div_result), 64'd0);
    check("rst_div_rem", 64'(o_div_remainder), 64'd0);
    #10 i_reset = 1'b1;

    // ALU directed
    do_alu(4'd0, 32'hFFFF_FFFF, 32'd1);
    do_alu(4'd1, 32'd5, 32'd7);
    do_alu(4'd7, 32'h8000_0000, 32'd33);
    do_alu(4'd8, 32'hFFFF_FFFF, 32'd1);
    do_alu(4'd9, 32'hFFFF_FFFF, 32'd1);
    do_alu(4'd14, 32'd3, 32'd3);
    do_alu(4'd15, 32'hFFFF_FFFF, 32'd0);
    @(negedge i_clock);
    i_alu_op = 4'd7;
    i_op1    = 32'h8000_0000;
    i_op2    = 32'd33;
    #1 check("sra_plan", 64'(o_shift_result), 64'hC000_0000);
    // ALU random
    for (int i = 0; i < 60; i++) begin
      do_alu(4'($urandom_range(0, 15)), $urandom, $urandom);
    end

    // Multiplier
    run_mul(32'hFFFF_FFFF, 32'd2, 1'b1);
    check("mul_signed_plan", o_mul_result, 64'hFFFF_FFFF_FFFF_FFFE);
    run_mul(32'hFFFF_FFFF, 32'd2, 1'b0);
    check("mul_unsigned_plan", o_mul_result, 64'h0000_0001_FFFF_FFFE);
    for (int i = 0; i < 6; i++) begin
      run_mul($urandom, $urandom, 1'($urandom));
    end

    // Divider directed
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1);
    check("div_signed_q_plan", 64'(o_div_result), 64'hFFFF_FFFD);
    check("div_signed_r_plan", 64'(o_div_remainder), 64'hFFFF_FFFF);
    run_div(32'd100, 32'd7, 1'b0);
    check("div_unsigned_q_plan", 64'(o_div_result), 64'd14);
    check("div_unsigned_r_plan", 64'(o_div_remainder), 64'd2);
    run_div(32'h1234_5678, 32'd0, 1'b0);
    run_div(32'h8765_4321, 32'd0, 1'b1);
    check("div0_q_plan", 64'(o_div_result), 64'hFFFF_FFFF);
    check("div0_r_plan", 64'(o_div_remainder), 64'h8765_4321);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("ovf_q_plan", 64'(o_div_result), 64'h8000_0000);
    check("ovf_r_plan", 64'(o_div_remainder), 64'd0);
    // Divider random
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
      if (i % 3 == 0) b = -b;
      run_div(a, b, 1'($urandom));
    end

    // Restart mid-division
    latch_ops(32'd1000, 32'd3, 1'b0);
    repeat (9) @(posedge i_clock);
    latch_ops(32'hFFFF_FF00, 32'd5, 1'b1);
    finish_div(32'hFFFF_FF00, 32'd5, 1'b1);

    // Asynchronous reset mid-division
    latch_ops(32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge i_clock);
    @(negedge i_clock);
    check("pre_rst_mul_done", 64'(o_mul_done), 64'd1);
    #2 i_reset = 1'b0;
    #1;
    check("arst_mul_done", 64'(o_mul_done), 64'd0);
    check("arst_mul_result", o_mul_result, 64'd0);
    check("arst_div_done", 64'(o_div_done), 64'd0);
    check("arst_div_result", 64'(o_div_result), 64'd0);
    check("arst_div_rem", 64'(o_div_remainder), 64'd0);
    #10 i_reset = 1'b1;
    repeat (40) @(posedge i_clock);
    @(negedge i_clock);
    check("post_rst_idle_done", 64'(o_div_done), 64'd0);
    run_div(32'd77, 32'd8, 1'b0);
    run_mul(32'd12345, 32'd678, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_arith_unit.md
Name: cpu_arith_unit

Overview:
- Integer datapath for the RV32 execute stage.
- Combines three parts:
  - A combinational ALU: add/sub/logic, shifts, compares and an address sum.
  - A pipelined 32x32->64 multiplier.
  - An iterative 32-bit divider with remainder.
- The execute stage feeds it register/immediate operands, starts the multiplier and divider with a shared latch strobe, and samples results when the done flags assert.

Parameters:
- none

Ports:
- i_clock  input  1  system clock; all registers update on the rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_alu_op  input  4  ALU operation code (encoding below).
- i_op1  input  32  ALU operand 1 / multiplicand / numerator.
- i_op2  input  32  ALU operand 2 / multiplier / denominator.
- i_latch  input  1  capture operands and start the multiplier and divider.
- i_signed  input  1  treat multiplier and divider operands as two's complement.
- o_result  output  32  arithmetic/logic result.
- o_shift_result  output  32  shift result.
- o_signed_sum_result  output  32  i_op1 + i_op2 modulo 2^32 for every i_alu_op (address generation).
- o_compare_result  output  1  compare result.
- o_mul_result  output  64  product.
- o_mul_done  output  1  product valid.
- o_div_result  output  32  quotient.
- o_div_remainder  output  32  remainder.
- o_div_done  output  1  quotient and remainder valid.

Behaviour:
ALU (purely combinational, no latency):
- Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 LT, 9 LTU, 10 EQ, 11 NE, 12 GE, 13 GEU; 14 and 15 reserved.
- o_result: valid for ops 0-4; 0 for all other ops. ADD/SUB wrap modulo 2^32.
- o_shift_result: valid for ops 5-7; 0 otherwise.
  - Shift amount is i_op2[4:0]; upper bits are ignored.
  - SRA replicates bit 31.
- o_compare_result: valid for ops 8-13; 0 otherwise.
  - LT and GE are signed compares.
  - LTU and GEU are unsigned compares.
- Reserved ops: o_result, o_shift_result and o_compare_result are all 0.

Multiplier:
- On a rising edge with i_latch=1: capture i_op1, i_op2 and i_signed, and clear o_mul_done.
- The 64-bit product is registered; o_mul_result and o_mul_done=1 are presented exactly 2 clocks after the latch edge.
- i_signed=1: both operands are signed (MUL, MULH). i_signed=0: both operands are unsigned (MULHU).
- Holding i_latch high re-captures every cycle and restarts the latency count.
- The result holds until the next latch.

Divider:
- On a rising edge with i_latch=1: capture the operands and i_signed, clear o_div_done, and start a restoring radix-2 loop of 32 iterations, one per clock.
- After the last iteration: o_div_done=1, and o_div_result/o_div_remainder are valid, 33 clocks after the latch edge.
- Signed mode:
  - Divide magnitudes.
  - Quotient is negative when the operand signs differ.
  - Remainder takes the sign of the numerator.
- Divide by zero (either mode): quotient 0xFFFFFFFF, remainder = numerator; done at the normal latency.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- A new i_latch mid-operation aborts the current division and restarts with the new operands.
- Results hold until the next latch.

Reset:
- Asserting i_reset (0) immediately clears all multiplier and divider registers: results 0, o_mul_done=0, o_div_done=0, any division in progress aborted.
- ALU outputs are unaffected by reset.
- Operation resumes on the first latch after reset releases.

Test Plan:
- ALU:
  - ADD 0xFFFFFFFF+1 -> o_result 0, o_signed_sum_result 0.
  - SUB 5-7 -> 0xFFFFFFFE.
  - SRA 0x80000000 by 33 -> o_shift_result 0xC0000000.
  - LT 0xFFFFFFFF,1 -> 1; LTU 0xFFFFFFFF,1 -> 0.
- Multiply:
  - Signed 0xFFFFFFFF*2 latched at edge N -> o_mul_result 0xFFFFFFFFFFFFFFFE and o_mul_done=1 at edge N+2.
  - Unsigned same operands -> 0x00000001FFFFFFFE.
- Divide:
  - Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF, o_div_done at edge N+33.
  - Unsigned 100/7 -> 14 r 2.
- Divide corner cases:
  - x/0 -> 0xFFFFFFFF r x.
  - Signed 0x80000000/0xFFFFFFFF -> 0x80000000 r 0.
- Restart: a second i_latch 10 cycles into a division -> only the second operands' result appears, 33 clocks after the second latch.
- Reset: assert i_reset mid-division -> done flags and results 0 without waiting for a clock edge; after release, a new latch completes normally.
